// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer used on the shared memory port datapath.
module mux2 #(
    parameter int W = 32
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters.
// Optional watchdog abort of stuck accesses is enabled with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              sel,
    output logic              stall,
    output logic              timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sel;
    logic              w_sel_nxt;
    logic              r_last_dm;
    logic              w_last_dm_nxt;
    logic              r_if_done;
    logic              r_dm_done;
    logic              w_if_done_nxt;
    logic              w_dm_done_nxt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [DATA_W-1:0] w_cpl_rdata;
    logic              w_if_elig;
    logic              w_dm_elig;
    logic              w_pick_dm;
    logic              w_tmo_hit;

    // A held request is stale while its own done pulse is showing.
    assign w_if_elig = if_req & ~r_if_done;
    assign w_dm_elig = dm_req & ~r_dm_done;
    assign w_pick_dm = w_dm_elig & (~w_if_elig | ~r_last_dm);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_tmo_err;

    assign w_tmo_hit = (r_state != IDLE) && !mem_ack &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_state == IDLE || mem_ack || w_tmo_hit)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_tmo_hit)
                r_tmo_err <= 1'b1;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // An aborted access returns zero data to the requester.
    assign w_cpl_rdata = mem_ack ? mem_rdata : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_last_dm_nxt = r_last_dm;
        w_if_done_nxt = 1'b0;
        w_dm_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_elig || w_dm_elig) begin
                    w_state_nxt = w_pick_dm ? SERVE_DM : SERVE_IF;
                    w_sel_nxt   = w_pick_dm ? SEL_DM : SEL_IF;
                end
            end
            SERVE_IF: begin
                if (mem_ack || w_tmo_hit) begin
                    w_state_nxt   = IDLE;
                    w_if_done_nxt = 1'b1;
                    w_last_dm_nxt = 1'b0;
                end
            end
            SERVE_DM: begin
                if (mem_ack || w_tmo_hit) begin
                    w_state_nxt   = IDLE;
                    w_dm_done_nxt = 1'b1;
                    w_last_dm_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= SEL_IF;
            r_last_dm  <= 1'b0;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_last_dm <= w_last_dm_nxt;
            r_if_done <= w_if_done_nxt;
            r_dm_done <= w_dm_done_nxt;
            if (w_if_done_nxt)
                r_if_rdata <= w_cpl_rdata;
            if (w_dm_done_nxt)
                r_dm_rdata <= w_cpl_rdata;
        end
    end

    mux2 #(.W(ADDR_W)) u_addr_mux (
        .i_sel (r_sel),
        .i_d0  (if_addr),
        .i_d1  (dm_addr),
        .o_y   (mem_addr)
    );

    mux2 #(.W(DATA_W)) u_wdata_mux (
        .i_sel (r_sel),
        .i_d0  ({DATA_W{1'b0}}),
        .i_d1  (dm_wdata),
        .o_y   (mem_wdata)
    );

    assign mem_req  = (r_state != IDLE);
    assign mem_we   = (r_sel == SEL_DM) ? dm_we : 1'b0;
    assign sel      = r_sel;
    assign if_done  = r_if_done;
    assign dm_done  = r_dm_done;
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;
    assign stall    = (if_req & ~r_if_done) | (dm_req & ~r_dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          sel;
    logic          stall;
    logic          timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_done     (dm_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .sel         (sel),
        .stall       (stall),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Vector record: inputs for one cycle and the outputs expected in it.
    // exp = {mem_req, sel, if_done, dm_done, stall, mem_we}
    typedef struct packed {
        logic       if_req;
        logic       dm_req;
        logic       dm_we;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [12];

    // Reference model: who owns the port, who was served last, visible outputs.
    int            m_owner;   // 0 none, 1 fetch, 2 data
    int            m_last;    // 1 fetch, 2 data
    int            m_cnt;
    logic          m_sel;
    logic          m_if_done;
    logic          m_dm_done;
    logic [DW-1:0] m_if_rdata;
    logic [DW-1:0] m_dm_rdata;
    logic          m_err;

    task automatic model_reset();
        m_owner    = 0;
        m_last     = 1;
        m_cnt      = 0;
        m_sel      = 1'b0;
        m_if_done  = 1'b0;
        m_dm_done  = 1'b0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
        m_err      = 1'b0;
    endtask

    task automatic model_edge();
        logic n_if_done;
        logic n_dm_done;
        bit   fin_ack;
        bit   fin_tmo;
        bit   want_if;
        bit   want_dm;
        n_if_done = 1'b0;
        n_dm_done = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_owner != 0) begin
            m_cnt++;
            fin_ack = mem_ack;
            fin_tmo = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            fin_tmo = !mem_ack && (m_cnt == TMO);
`endif
            if (fin_ack || fin_tmo) begin
                if (m_owner == 1) begin
                    n_if_done  = 1'b1;
                    m_if_rdata = fin_ack ? mem_rdata : '0;
                end else begin
                    n_dm_done  = 1'b1;
                    m_dm_rdata = fin_ack ? mem_rdata : '0;
                end
                if (fin_tmo) m_err = 1'b1;
                m_last  = m_owner;
                m_owner = 0;
            end
        end else begin
            want_if = if_req && !m_if_done;
            want_dm = dm_req && !m_dm_done;
            if (want_if && want_dm) m_owner = (m_last == 1) ? 2 : 1;
            else if (want_if)       m_owner = 1;
            else if (want_dm)       m_owner = 2;
            if (m_owner != 0) begin
                m_sel = (m_owner == 2);
                m_cnt = 0;
            end
        end
        m_if_done = n_if_done;
        m_dm_done = n_dm_done;
    endtask

    task automatic model_compare();
        logic [AW-1:0] e_addr;
        logic          e_stall;
        e_addr  = m_sel ? dm_addr : if_addr;
        e_stall = (if_req & ~m_if_done) | (dm_req & ~m_dm_done);
        chk("rand ctl {mem_req,sel,if_done,dm_done,stall,timeout_err}",
            {mem_req, sel, if_done, dm_done, stall, timeout_err},
            {(m_owner != 0), m_sel, m_if_done, m_dm_done, e_stall, m_err});
        chk("rand if_rdata", if_rdata, m_if_rdata);
        chk("rand dm_rdata", dm_rdata, m_dm_rdata);
        chk("rand mem_addr", mem_addr, e_addr);
        chk("rand mem_we", mem_we, m_sel ? dm_we : 1'b0);
        if (m_sel) chk("rand mem_wdata", mem_wdata, dm_wdata);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int bad;

        tbl[0]  = 10'b1100_000010;
        tbl[1]  = 10'b1100_110010;
        tbl[2]  = 10'b1101_110010;
        tbl[3]  = 10'b1100_010110;
        tbl[4]  = 10'b1101_100010;
        tbl[5]  = 10'b1100_001010;
        tbl[6]  = 10'b1101_110010;
        tbl[7]  = 10'b1100_010110;
        tbl[8]  = 10'b1001_100010;
        tbl[9]  = 10'b0000_001000;
        tbl[10] = 10'b0001_000000;
        tbl[11] = 10'b0000_000000;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset ctl {mem_req,sel,if_done,dm_done,stall,timeout_err}",
            {mem_req, sel, if_done, dm_done, stall, timeout_err}, 6'b0);
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset dm_rdata", dm_rdata, 32'h0);
        next_cycle();

        // Simultaneous requests after reset, then alternation, then ack in idle
        do_reset();
        if_addr = 32'h100;
        dm_addr = 32'h200;
        for (int i = 0; i < 12; i++) begin
            if_req    = tbl[i].if_req;
            dm_req    = tbl[i].dm_req;
            dm_we     = tbl[i].dm_we;
            mem_ack   = tbl[i].ack;
            mem_rdata = 32'hA000_0000 + i;
            @(negedge clk);
            chk($sformatf("tbl[%0d] {mem_req,sel,if_done,dm_done,stall,mem_we}", i),
                {mem_req, sel, if_done, dm_done, stall, mem_we}, tbl[i].exp);
            if (tbl[i].exp[5])
                chk($sformatf("tbl[%0d] mem_addr", i), mem_addr, tbl[i].exp[4] ? 32'h200 : 32'h100);
            if (tbl[i].exp[3])
                chk($sformatf("tbl[%0d] if_rdata", i), if_rdata, 32'hA000_0000 + i - 1);
            if (tbl[i].exp[2])
                chk($sformatf("tbl[%0d] dm_rdata", i), dm_rdata, 32'hA000_0000 + i - 1);
            next_cycle();
        end

        // Lone fetch with ack in the first serve cycle
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h100;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("fetch c0 {mem_req,sel}", {mem_req, sel}, 2'b00);
        next_cycle();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("fetch c1 {mem_req,sel,mem_we,if_done}", {mem_req, sel, mem_we, if_done}, 4'b1000);
        chk("fetch c1 mem_addr", mem_addr, 32'h100);
        next_cycle();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        @(negedge clk);
        chk("fetch c2 {if_done,sel,mem_req}", {if_done, sel, mem_req}, 3'b100);
        chk("fetch c2 if_rdata", if_rdata, 32'h1234_5678);
        next_cycle();
        @(negedge clk);
        chk("fetch c3 if_done", if_done, 1'b0);
        next_cycle();

        // Data write, ack in the third serve cycle
        cnt = 0;
        bad = 0;
        dm_addr   = 32'h200;
        dm_wdata  = 32'hDEAD_BEEF;
        mem_rdata = 32'h0BAD_F00D;
        for (int k = 0; k < 7; k++) begin
            dm_req  = (k < 4);
            dm_we   = (k < 4);
            mem_ack = (k == 3);
            @(negedge clk);
            if (mem_req !== (k >= 1 && k <= 3)) bad++;
            if (k >= 1 && k <= 3) begin
                if (mem_we !== 1'b1 || sel !== 1'b1) bad++;
                if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) bad++;
            end
            if (dm_done === 1'b1) cnt++;
            next_cycle();
        end
        chk("write port signal errors", bad, 0);
        chk("write dm_done pulses", cnt, 1);
        chk("write dm_rdata", dm_rdata, 32'h0BAD_F00D);
        chk("if_rdata held", if_rdata, 32'h1234_5678);

        // Fetch request dropped mid-service still completes
        if_req    = 1'b1;
        if_addr   = 32'h140;
        mem_rdata = 32'h55AA_55AA;
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        chk("drop c1 mem_req", mem_req, 1'b1);
        next_cycle();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("drop c2 {mem_req,if_done}", {mem_req, if_done}, 2'b10);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("drop c3 {if_done,stall}", {if_done, stall}, 2'b10);
        chk("drop c3 if_rdata", if_rdata, 32'h55AA_55AA);
        next_cycle();

        // Reset in the second data serve cycle
        dm_req = 1'b1;
        dm_we  = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rst c1 {mem_req,sel}", {mem_req, sel}, 2'b11);
        next_cycle();
        reset   = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("rst c2 mem_req", mem_req, 1'b1);
        next_cycle();
        reset   = 1'b0;
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        @(negedge clk);
        chk("rst c3 {mem_req,sel,if_done,dm_done,timeout_err}",
            {mem_req, sel, if_done, dm_done, timeout_err}, 5'b0);
        chk("rst c3 if_rdata", if_rdata, 32'h0);
        chk("rst c3 dm_rdata", dm_rdata, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rst c4 {dm_done,mem_req}", {dm_done, mem_req}, 2'b00);
        next_cycle();

        // Prime dm_rdata with a non-zero value
        dm_req    = 1'b1;
        mem_rdata = 32'h0000_0077;
        next_cycle();
        mem_ack = 1'b1;
        next_cycle();
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        @(negedge clk);
        chk("prime dm_done", dm_done, 1'b1);
        chk("prime dm_rdata", dm_rdata, 32'h77);
        next_cycle();

        // Access never acknowledged
        cnt = 0;
        bad = 0;
        dm_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 0; k < TMO + 6; k++) begin
            if (k == TMO + 1) dm_req = 1'b0;
            @(negedge clk);
            if (mem_req !== (k >= 1 && k <= TMO)) bad++;
            if (dm_done === 1'b1) cnt++;
            if (k == TMO + 1) begin
                chk("tmo dm_done", dm_done, 1'b1);
                chk("tmo dm_rdata", dm_rdata, 32'h0);
                chk("tmo timeout_err", timeout_err, 1'b1);
            end
            next_cycle();
        end
        chk("tmo mem_req profile errors", bad, 0);
        chk("tmo dm_done pulses", cnt, 1);
        chk("tmo timeout_err sticky", timeout_err, 1'b1);
        do_reset();
        @(negedge clk);
        chk("tmo timeout_err after reset", timeout_err, 1'b0);
        next_cycle();
`else
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k >= 1 && mem_req !== 1'b1) bad++;
            if (dm_done === 1'b1 || timeout_err !== 1'b0) cnt++;
            next_cycle();
        end
        chk("no-ack mem_req held errors", bad, 0);
        chk("no-ack spurious done/err", cnt, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0099;
        next_cycle();
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        @(negedge clk);
        chk("late ack dm_done", dm_done, 1'b1);
        chk("late ack dm_rdata", dm_rdata, 32'h99);
        next_cycle();
`endif

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!(if_req && !m_if_done)) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end else if ($urandom_range(0, 49) == 0) begin
                if_req = 1'b0;
            end
            if (!(dm_req && !m_dm_done)) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = $urandom_range(0, 1);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end else if ($urandom_range(0, 49) == 0) begin
                dm_req = 1'b0;
            end
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            model_compare();
            @(posedge clk);
            model_edge();
            #1;
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
